fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and a small return stack, and drives a synchronous instruction memory.
- Delivers the current instruction word and opcode to the control unit.
- Consumes the control unit's sequencing outputs (s_inc, s_inc2, fin, s_call, s_ret) to form the next PC each cycle.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/ret_stack.sv | 53 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/instruction widths, opcode field, fetch states, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int AW      = 10;           // PC / instruction-address width
    localparam int IW      = 16;           // instruction width
    localparam int OPC_W   = 6;            // opcode field width
    localparam int OPC_MSB = IW - 1;       // opcode occupies the top bits of the word
    localparam int OPC_LSB = IW - OPC_W;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    // Opcodes shared with the control unit
    localparam logic [OPC_W-1:0] OP_ALU  = 6'h00;
    localparam logic [OPC_W-1:0] OP_LOAD = 6'h01;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'h02;
    localparam logic [OPC_W-1:0] OP_JZ   = 6'h03;
    localparam logic [OPC_W-1:0] OP_JNZ  = 6'h04;
    localparam logic [OPC_W-1:0] OP_JREL = 6'h05;
    localparam logic [OPC_W-1:0] OP_CALL = 6'h06;
    localparam logic [OPC_W-1:0] OP_RET  = 6'h07;
    localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO (DEPTH x AW); dout is the top entry, combinational from the pointer.
// Latency: push/pop take effect at the next clock edge; dout/full/empty are combinational.
// Backpressure: none; caller must not push when full or pop when empty (such requests are dropped).
// Ports: clk, reset (sync, active-low, clears pointer only), push, pop, din, dout, full, empty.
import cpu_pkg::*;

module ret_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);

    // One extra pointer bit so that sp == DEPTH (full) is representable.
    localparam int IDXW = $clog2(DEPTH);
    localparam int SPW  = IDXW + 1;

    logic [AW-1:0]   entries [DEPTH];
    logic [SPW-1:0]  sp;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] top_idx;

    assign wr_idx  = sp[IDXW-1:0];
    assign top_idx = sp[IDXW-1:0] - IDXW'(1);
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign dout    = entries[top_idx];

    // Storage is not reset; only the pointer defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC and return stack, drives sync instruction memory, forms next PC.
// Latency: imem_addr = next_pc combinationally, so instr lines up with pc one cycle later; one boot bubble.
// Backpressure: none; sequencing inputs are honoured only while valid=1, HALT is absorbing until reset.
// Ports: clk, reset (sync, active-low); s_inc/s_inc2/fin/s_call/s_ret/jmp_addr from control unit;
//        imem_addr/imem_rdata to memory; instr/opcode/pc/valid/halted/stack_err to control unit.
import cpu_pkg::*;

module fetch_unit #(
    parameter int AW          = cpu_pkg::AW,
    parameter int IW          = cpu_pkg::IW,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_inc,
    input  logic             s_inc2,
    input  logic             fin,
    input  logic             s_call,
    input  logic             s_ret,
    input  logic [AW-1:0]    jmp_addr,
    output logic [AW-1:0]    imem_addr,
    input  logic [IW-1:0]    imem_rdata,
    output logic [IW-1:0]    instr,
    output logic [OPC_W-1:0] opcode,
    output logic [AW-1:0]    pc,
    output logic             valid,
    output logic             halted,
    output logic             stack_err
);

    fetch_state_t  state;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] stk_dout;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;
    logic          err;
    logic          go_halt;

    assign instr    = imem_rdata;
    assign opcode   = imem_rdata[IW-1 -: OPC_W];
    assign ret_addr = pc + AW'(1);   // wraps at 2^AW like the PC itself

    // Next-PC selection. Outside S_RUN everything holds, which also makes
    // imem_addr = pc in HALT and keeps the stack untouched.
    always_comb begin
        next_pc = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err     = 1'b0;
        go_halt = 1'b0;
        if (state == S_RUN) begin
            if (fin) begin
                go_halt = 1'b1;
            end else if (s_ret) begin
                if (stk_empty) begin
                    err     = 1'b1;
                    go_halt = 1'b1;
                end else begin
                    pop     = 1'b1;
                    next_pc = stk_dout;
                end
            end else if (s_call) begin
                if (stk_full) begin
                    err     = 1'b1;
                    go_halt = 1'b1;
                end else begin
                    push    = 1'b1;
                    next_pc = jmp_addr;
                end
            end else if (!s_inc) begin
                next_pc = jmp_addr;
            end else if (s_inc2) begin
                next_pc = pc + jmp_addr;   // two's-complement offset, modulo 2^AW
            end else begin
                next_pc = pc + AW'(1);
            end
        end
    end

    // Address is forced to 0 during reset and the boot bubble so that the
    // word at address 0 is waiting when the PC first becomes valid.
    assign imem_addr = (!reset || state == S_BOOT) ? '0 : next_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_BOOT;
            pc        <= '0;
            valid     <= 1'b0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_RUN;
                    pc    <= '0;
                    valid <= 1'b1;
                end
                S_RUN: begin
                    pc <= next_pc;
                    if (err) begin
                        stack_err <= 1'b1;
                    end
                    if (go_halt) begin
                        state  <= S_HALT;
                        valid  <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    // absorbing until reset
                end
                default: begin
                    state <= S_BOOT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (AW)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural synchronous instruction memory.
// Latency: memory returns data one cycle after the address.
// Backpressure: n/a.
import cpu_pkg::*;

module tb_fetch_unit;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_inc, s_inc2, fin, s_call, s_ret;
    logic [9:0]       jmp_addr;
    logic [9:0]       imem_addr;
    logic [15:0]      imem_rdata;
    logic [15:0]      instr;
    logic [5:0]       opcode;
    logic [9:0]       pc;
    logic             valid, halted, stack_err;

    logic [15:0]      mem [1024];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    fetch_unit #(.AW(10), .IW(16), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_inc      (s_inc),
        .s_inc2     (s_inc2),
        .fin        (fin),
        .s_call     (s_call),
        .s_ret      (s_ret),
        .jmp_addr   (jmp_addr),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .valid      (valid),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_inc = 1'b1; s_inc2 = 1'b0; fin = 1'b0; s_call = 1'b0; s_ret = 1'b0; jmp_addr = '0;
    endtask

    // Apply one cycle of sequencing inputs, let it take effect, return to plain increment.
    task automatic drive(input logic inc, input logic inc2, input logic f,
                         input logic call, input logic ret, input logic [9:0] addr);
        s_inc = inc; s_inc2 = inc2; fin = f; s_call = call; s_ret = ret; jmp_addr = addr;
        tick();
        idle();
    endtask

    task automatic jump_to(input logic [9:0] addr);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, addr);
    endtask

    task automatic reset_boot();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        #0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #1;
        n_total++; if (imem_addr !== 10'h000) $display("FAIL rst_addr: got %h want 000", imem_addr); else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0 || pc !== 10'h000)
            $display("FAIL rst_state: valid=%b halted=%b err=%b pc=%h want 0/0/0/000", valid, halted, stack_err, pc);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (valid !== 1'b0 || imem_addr !== 10'h000)
            $display("FAIL boot_bubble: valid=%b addr=%h want 0/000", valid, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b1 || pc !== 10'h000 || instr !== 16'h0000 || opcode !== 6'h00)
            $display("FAIL boot_first: valid=%b pc=%h instr=%h want 1/000/0000", valid, pc, instr);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total++;
            if (pc !== 10'(k) || instr !== 16'(k) || valid !== 1'b1)
                $display("FAIL boot_incr: pc=%h instr=%h want %h", pc, instr, 10'(k));
            else n_pass++;
        end
    endtask

    task automatic test_abs_jump();
        tick();
        tick();
        n_total++; if (pc !== 10'h005) $display("FAIL abs_pre: pc=%h want 005", pc); else n_pass++;
        s_inc = 1'b0; jmp_addr = 10'h120;
        #1;
        n_total++; if (imem_addr !== 10'h120) $display("FAIL abs_addr: got %h want 120", imem_addr); else n_pass++;
        tick();
        idle();
        n_total++;
        if (pc !== 10'h120 || valid !== 1'b1 || instr !== 16'h0920 || opcode !== OP_JMP)
            $display("FAIL abs_land: pc=%h valid=%b instr=%h op=%h want 120/1/0920/02", pc, valid, instr, opcode);
        else n_pass++;
    endtask

    task automatic test_rel_jump();
        jump_to(10'h010);
        s_inc = 1'b1; s_inc2 = 1'b1; jmp_addr = 10'h3FE;
        #1;
        n_total++; if (imem_addr !== 10'h00E) $display("FAIL rel_back_addr: got %h want 00E", imem_addr); else n_pass++;
        tick();
        idle();
        n_total++;
        if (pc !== 10'h00E || instr !== 16'h000E)
            $display("FAIL rel_back: pc=%h instr=%h want 00E", pc, instr);
        else n_pass++;
        jump_to(10'h3FF);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h002);
        n_total++; if (pc !== 10'h001) $display("FAIL rel_wrap: pc=%h want 001", pc); else n_pass++;
        jump_to(10'h3FF);
        tick();
        n_total++;
        if (pc !== 10'h000 || instr !== 16'h0000)
            $display("FAIL inc_wrap: pc=%h instr=%h want 000", pc, instr);
        else n_pass++;
    endtask

    task automatic test_call_ret();
        jump_to(10'h040);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h200);
        n_total++; if (pc !== 10'h200) $display("FAIL call1: pc=%h want 200", pc); else n_pass++;
        jump_to(10'h210);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300);
        n_total++; if (pc !== 10'h300) $display("FAIL call2: pc=%h want 300", pc); else n_pass++;
        jump_to(10'h305);
        s_ret = 1'b1;
        #1;
        n_total++; if (imem_addr !== 10'h211) $display("FAIL ret1_addr: got %h want 211", imem_addr); else n_pass++;
        tick();
        idle();
        n_total++; if (pc !== 10'h211) $display("FAIL ret1: pc=%h want 211", pc); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        n_total++; if (pc !== 10'h041) $display("FAIL ret2: pc=%h want 041", pc); else n_pass++;
        // Fill the stack, then one call too many.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'(10'h100 + k));
        n_total++; if (pc !== 10'h103 || stack_err !== 1'b0) $display("FAIL fill: pc=%h err=%b want 103/0", pc, stack_err); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h104);
        n_total++;
        if (stack_err !== 1'b1 || halted !== 1'b1 || valid !== 1'b0 || pc !== 10'h103 || imem_addr !== 10'h103)
            $display("FAIL overflow: err=%b halted=%b valid=%b pc=%h addr=%h want 1/1/0/103/103",
                     stack_err, halted, valid, pc, imem_addr);
        else n_pass++;
    endtask

    task automatic test_underflow();
        reset_boot();
        n_total++; if (stack_err !== 1'b0 || halted !== 1'b0) $display("FAIL err_clear: err=%b halted=%b want 0/0", stack_err, halted); else n_pass++;
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h200);   // call+ret together: ret wins, stack empty
        n_total++;
        if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 10'h002)
            $display("FAIL underflow: err=%b halted=%b pc=%h want 1/1/002", stack_err, halted, pc);
        else n_pass++;
    endtask

    task automatic test_fin();
        reset_boot();
        jump_to(10'h033);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        n_total++;
        if (halted !== 1'b1 || valid !== 1'b0 || pc !== 10'h033 || stack_err !== 1'b0)
            $display("FAIL fin: halted=%b valid=%b pc=%h err=%b want 1/0/033/0", halted, valid, pc, stack_err);
        else n_pass++;
        s_inc = 1'b0; jmp_addr = 10'h200;
        #1;
        n_total++; if (imem_addr !== 10'h033) $display("FAIL halt_addr: got %h want 033", imem_addr); else n_pass++;
        tick();
        tick();
        idle();
        n_total++;
        if (pc !== 10'h033 || halted !== 1'b1 || valid !== 1'b0)
            $display("FAIL halt_hold: pc=%h halted=%b valid=%b want 033/1/0", pc, halted, valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        reset_boot();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h180);
        s_call = 1'b1; jmp_addr = 10'h1C0; reset = 1'b0;
        #1;
        n_total++; if (imem_addr !== 10'h000) $display("FAIL mid_rst_addr: got %h want 000", imem_addr); else n_pass++;
        tick();
        reset = 1'b1;
        idle();
        #1;
        n_total++;
        if (pc !== 10'h000 || valid !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0 || imem_addr !== 10'h000)
            $display("FAIL mid_rst: pc=%h valid=%b halted=%b err=%b addr=%h want 000/0/0/0/000",
                     pc, valid, halted, stack_err, imem_addr);
        else n_pass++;
        tick();
        n_total++; if (valid !== 1'b1 || pc !== 10'h000) $display("FAIL mid_reboot: valid=%b pc=%h want 1/000", valid, pc); else n_pass++;
        // Stack pointer must have been cleared: a return now underflows.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        n_total++; if (stack_err !== 1'b1 || pc !== 10'h000) $display("FAIL mid_sp: err=%b pc=%h want 1/000", stack_err, pc); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {6'b0, 10'(i)};
        mem[10'h120] = {OP_JMP, 10'h120};
        reset = 1'b0;
        idle();
        tick();
        test_reset();
        test_abs_jump();
        test_rel_jump();
        test_call_ret();
        test_underflow();
        test_fin();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
